// File: rtl/issue_pkg.sv
// Shared configuration and types for the issue scheduler: entry-index width,
// per-FU grant record and the stall-counter saturation value.
package issue_pkg;

    localparam int unsigned RS_ENTRIES = 16;
    localparam int unsigned NUM_FU     = 3;
    localparam int unsigned ENTRY_W    = $clog2(RS_ENTRIES);

    localparam logic [31:0] STALL_SAT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic               valid;
        logic [ENTRY_W-1:0] entry;
    } fu_grant_t;

endpackage

// File: rtl/fu_issue_scheduler_rr_multi_picker.sv
// Combinational round-robin multi-picker: rotates the eligible-entry mask to
// start at rr_ptr, binds the j-th eligible entry to the j-th free FU, unrotates.
module rr_multi_picker
    import issue_pkg::*;
(
    input  logic [RS_ENTRIES-1:0] elig_rs,
    input  logic [ENTRY_W-1:0]    rr_ptr,
    input  logic [NUM_FU-1:0]     elig_fu,
    output fu_grant_t [NUM_FU-1:0] grant,
    output logic [RS_ENTRIES-1:0] clear,
    output logic [ENTRY_W-1:0]    next_ptr
);

    logic [RS_ENTRIES-1:0] rot;
    logic [NUM_FU-1:0]     fu_taken;
    logic [ENTRY_W-1:0]    idx;
    logic                  placed;

    // rot[i] is the entry i positions after rr_ptr; the index add wraps mod RS_ENTRIES.
    always_comb begin
        rot = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            rot[i] = elig_rs[ENTRY_W'(i) + rr_ptr];
        end
    end

    always_comb begin
        grant    = '0;
        clear    = '0;
        next_ptr = rr_ptr;
        fu_taken = '0;
        idx      = '0;
        placed   = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            idx    = ENTRY_W'(i) + rr_ptr;
            placed = 1'b0;
            if (rot[i]) begin
                for (int k = 0; k < NUM_FU; k++) begin
                    if (!placed && elig_fu[k] && !fu_taken[k]) begin
                        placed         = 1'b1;
                        fu_taken[k]    = 1'b1;
                        grant[k].valid = 1'b1;
                        grant[k].entry = idx;
                        clear[idx]     = 1'b1;
                        next_ptr       = idx + ENTRY_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Issue-stage scheduler: registered round-robin binding of ready RS entries
// to available functional units, with one-cycle hazard masking and a stall counter.
module fu_issue_scheduler
    import issue_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [RS_ENTRIES-1:0]     rs_ready,
    input  logic [NUM_FU-1:0]         fu_is_available,
    output logic [NUM_FU-1:0]         issue_valid,
    output logic [NUM_FU*ENTRY_W-1:0] issue_entry,
    output logic [RS_ENTRIES-1:0]     rs_clear,
    output logic [31:0]               stall_cycles
);

    logic [ENTRY_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [NUM_FU-1:0]               issue_valid_q, issue_valid_d;
    logic [NUM_FU-1:0][ENTRY_W-1:0]  issue_entry_q, issue_entry_d;
    logic [RS_ENTRIES-1:0]           rs_clear_q, rs_clear_d;
    logic [31:0]                     stall_q, stall_d;

    logic [RS_ENTRIES-1:0] elig_rs;
    logic [NUM_FU-1:0]     elig_fu;
    fu_grant_t [NUM_FU-1:0] grant;
    logic [RS_ENTRIES-1:0] pick_clear;
    logic [ENTRY_W-1:0]    pick_next_ptr;

    // Grants registered last cycle are not yet visible in rs_ready/fu_is_available.
    assign elig_rs = rs_ready & ~rs_clear_q;
    assign elig_fu = fu_is_available & ~issue_valid_q;

    rr_multi_picker u_picker (
        .elig_rs  (elig_rs),
        .rr_ptr   (rr_ptr_q),
        .elig_fu  (elig_fu),
        .grant    (grant),
        .clear    (pick_clear),
        .next_ptr (pick_next_ptr)
    );

    always_comb begin
        issue_valid_d = '0;
        issue_entry_d = issue_entry_q;
        rs_clear_d    = '0;
        rr_ptr_d      = rr_ptr_q;
        stall_d       = stall_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d   = pick_next_ptr;
            rs_clear_d = pick_clear;
            for (int k = 0; k < NUM_FU; k++) begin
                if (grant[k].valid) begin
                    issue_valid_d[k] = 1'b1;
                    issue_entry_d[k] = grant[k].entry;
                end
            end
        end
        if ((|elig_rs) && !(|elig_fu) && !flush && (stall_q != STALL_SAT)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q      <= '0;
            issue_valid_q <= '0;
            issue_entry_q <= '0;
            rs_clear_q    <= '0;
            stall_q       <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_entry_q <= issue_entry_d;
            rs_clear_q    <= rs_clear_d;
            stall_q       <= stall_d;
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_entry  = issue_entry_q;
    assign rs_clear     = rs_clear_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Self-checking bench for fu_issue_scheduler: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fu_issue_scheduler;
    import issue_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      flush = 1'b0;
    logic [RS_ENTRIES-1:0]     rs_ready = '0;
    logic [NUM_FU-1:0]         fu_is_available = '0;
    logic [NUM_FU-1:0]         issue_valid;
    logic [NUM_FU*ENTRY_W-1:0] issue_entry;
    logic [RS_ENTRIES-1:0]     rs_clear;
    logic [31:0]               stall_cycles;

    fu_issue_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .rs_ready        (rs_ready),
        .fu_is_available (fu_is_available),
        .issue_valid     (issue_valid),
        .issue_entry     (issue_entry),
        .rs_clear        (rs_clear),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [RS_ENTRIES-1:0]          rs;
        logic [NUM_FU-1:0]              fu;
        logic                           fl;
        logic [NUM_FU-1:0]              v;
        logic [RS_ENTRIES-1:0]          clr;
        logic [NUM_FU-1:0][ENTRY_W-1:0] e;
        logic [31:0]                    stall;
    } vec_t;

    vec_t tbl[9];

    // Reference model state
    logic [NUM_FU-1:0]     m_valid;
    logic [RS_ENTRIES-1:0] m_clear;
    int                    m_entry[NUM_FU];
    int                    m_ptr;
    logic [31:0]           m_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] ent(input int k);
        return issue_entry[k*ENTRY_W +: ENTRY_W];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [NUM_FU-1:0] v,
                              input logic [RS_ENTRIES-1:0] clr,
                              input logic [NUM_FU-1:0][ENTRY_W-1:0] e,
                              input logic [31:0] stall);
        check({tag, " valid"}, 64'(issue_valid), 64'(v));
        check({tag, " clear"}, 64'(rs_clear), 64'(clr));
        check({tag, " stall"}, 64'(stall_cycles), 64'(stall));
        for (int k = 0; k < NUM_FU; k++) begin
            if (v[k]) check($sformatf("%s entry%0d", tag, k), 64'(ent(k)), 64'(e[k]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush = 1'b0;
        rs_ready = '0;
        fu_is_available = '0;
        cycle();
        reset = 1'b1;
    endtask

    // Spec-level model: list eligible entries in scan order, list free FUs
    // in ascending order, and pair them up.
    task automatic model_step();
        int q_rs[$];
        int q_fu[$];
        int n;
        logic [NUM_FU-1:0]     nv;
        logic [RS_ENTRIES-1:0] nc;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            int e;
            e = (m_ptr + i) % RS_ENTRIES;
            if (rs_ready[e] && !m_clear[e]) q_rs.push_back(e);
        end
        for (int k = 0; k < NUM_FU; k++) begin
            if (fu_is_available[k] && !m_valid[k]) q_fu.push_back(k);
        end
        if (q_rs.size() > 0 && q_fu.size() == 0 && !flush && m_stall != 32'hFFFF_FFFF)
            m_stall = m_stall + 1;
        nv = '0;
        nc = '0;
        if (flush) begin
            m_ptr = 0;
        end else begin
            n = (q_rs.size() < q_fu.size()) ? q_rs.size() : q_fu.size();
            for (int j = 0; j < n; j++) begin
                nv[q_fu[j]]      = 1'b1;
                m_entry[q_fu[j]] = q_rs[j];
                nc[q_rs[j]]      = 1'b1;
                m_ptr            = (q_rs[j] + 1) % RS_ENTRIES;
            end
        end
        m_valid = nv;
        m_clear = nc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'h0005, 3'b111, 1'b0, 3'b011, 16'h0005, {4'd0, 4'd2, 4'd0}, 32'd0};
        tbl[1] = '{16'h0005, 3'b111, 1'b0, 3'b000, 16'h0000, {4'd0, 4'd0, 4'd0}, 32'd0};
        tbl[2] = '{16'h0000, 3'b111, 1'b0, 3'b000, 16'h0000, {4'd0, 4'd0, 4'd0}, 32'd0};
        tbl[3] = '{16'h8001, 3'b001, 1'b0, 3'b001, 16'h8000, {4'd0, 4'd0, 4'd15}, 32'd0};
        tbl[4] = '{16'h8001, 3'b001, 1'b0, 3'b000, 16'h0000, {4'd0, 4'd0, 4'd0}, 32'd1};
        tbl[5] = '{16'h0001, 3'b001, 1'b0, 3'b001, 16'h0001, {4'd0, 4'd0, 4'd0}, 32'd1};
        tbl[6] = '{16'h0000, 3'b001, 1'b0, 3'b000, 16'h0000, {4'd0, 4'd0, 4'd0}, 32'd1};
        tbl[7] = '{16'h0003, 3'b001, 1'b0, 3'b001, 16'h0002, {4'd0, 4'd0, 4'd1}, 32'd1};
        tbl[8] = '{16'h0001, 3'b000, 1'b0, 3'b000, 16'h0000, {4'd0, 4'd0, 4'd0}, 32'd2};

        // Reset held with everything ready: outputs stay zero.
        reset = 1'b0;
        rs_ready = 16'hFFFF;
        fu_is_available = 3'b111;
        cycle();
        check("reset valid", 64'(issue_valid), 64'd0);
        check("reset entry", 64'(issue_entry), 64'd0);
        check("reset clear", 64'(rs_clear), 64'd0);
        check("reset stall", 64'(stall_cycles), 64'd0);
        reset = 1'b1;
        cycle();
        expect_out("first issue", 3'b111, 16'h0007, {4'd2, 4'd1, 4'd0}, 32'd0);

        // Directed table: basic, masking, wrap and fairness.
        do_reset();
        for (int r = 0; r < 9; r++) begin
            rs_ready = tbl[r].rs;
            fu_is_available = tbl[r].fu;
            flush = tbl[r].fl;
            cycle();
            expect_out($sformatf("row%0d", r), tbl[r].v, tbl[r].clr, tbl[r].e, tbl[r].stall);
        end

        // FU saturation then FU2 only.
        do_reset();
        rs_ready = 16'h00FF;
        fu_is_available = 3'b000;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("sat valid%0d", i), 64'(issue_valid), 64'd0);
        end
        check("sat stall", 64'(stall_cycles), 64'd5);
        fu_is_available = 3'b100;
        cycle();
        expect_out("sat fu2", 3'b100, 16'h0001, {4'd0, 4'd0, 4'd0}, 32'd5);

        // Flush: pending issue pulses once, nothing new, pointer back to 0.
        do_reset();
        rs_ready = 16'h0002;
        fu_is_available = 3'b111;
        cycle();
        expect_out("fl pre", 3'b001, 16'h0002, {4'd0, 4'd0, 4'd1}, 32'd0);
        rs_ready = 16'h0010;
        flush = 1'b1;
        cycle();
        expect_out("fl cyc", 3'b000, 16'h0000, {4'd0, 4'd0, 4'd0}, 32'd0);
        fu_is_available = 3'b000;
        cycle();
        expect_out("fl nostall", 3'b000, 16'h0000, {4'd0, 4'd0, 4'd0}, 32'd0);
        flush = 1'b0;
        rs_ready = 16'h0011;
        fu_is_available = 3'b001;
        cycle();
        expect_out("fl ptr0", 3'b001, 16'h0001, {4'd0, 4'd0, 4'd0}, 32'd0);

        // Asynchronous reset while three issues are presented.
        do_reset();
        rs_ready = 16'h0007;
        fu_is_available = 3'b111;
        cycle();
        expect_out("ar pre", 3'b111, 16'h0007, {4'd2, 4'd1, 4'd0}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("ar valid", 64'(issue_valid), 64'd0);
        check("ar entry", 64'(issue_entry), 64'd0);
        check("ar clear", 64'(rs_clear), 64'd0);
        cycle();
        reset = 1'b1;

        // Randomized traffic against the reference model.
        do_reset();
        m_valid = '0;
        m_clear = '0;
        m_ptr = 0;
        m_stall = '0;
        for (int k = 0; k < NUM_FU; k++) m_entry[k] = 0;
        for (int it = 0; it < 400; it++) begin
            rs_ready = (it % 3 == 0) ? RS_ENTRIES'($urandom) : RS_ENTRIES'($urandom & $urandom);
            fu_is_available = NUM_FU'($urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            model_step();
            cycle();
            check($sformatf("rnd%0d valid", it), 64'(issue_valid), 64'(m_valid));
            check($sformatf("rnd%0d clear", it), 64'(rs_clear), 64'(m_clear));
            check($sformatf("rnd%0d stall", it), 64'(stall_cycles), 64'(m_stall));
            for (int k = 0; k < NUM_FU; k++) begin
                if (m_valid[k])
                    check($sformatf("rnd%0d entry%0d", it, k), 64'(ent(k)), 64'(m_entry[k]));
            end
        end
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
